// File: rtl/data_cache_controller.sv
// data_cache_controller
//   Direct-mapped, write-through, no-write-allocate data cache between the
//   load/store path and main memory. Read misses refill a whole line one word
//   at a time over a req/ack handshake; stores always go to memory and update
//   the cached copy only when the line is already present.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   rd_en, wr_en        : load / store request, held until hit (store wins)
//   is_byte             : byte access (LB/SB) when 1, word access when 0
//   addr, wdata         : byte address {tag,index,word,byte}, store data
//   rdata, hit          : load data (LB sign-extended), access-complete strobe
//   mem_req, mem_we     : memory request, write (1) / read (0)
//   mem_addr, mem_wdata : word-aligned memory address, write data
//   mem_be              : memory byte enables
//   mem_rdata, mem_ack  : memory read data, one-cycle completion of mem_req
//   miss_count          : read-miss counter (wraps)
module data_cache_controller #(
  parameter int INDEX_BITS     = 5,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        is_byte,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] miss_count
);

  localparam int NUM_LINES   = 1 << INDEX_BITS;
  localparam int WORD_BITS   = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM, WDONE} state_t;

  state_t state, state_next;

  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [WORD_BITS-1:0] refill_cnt;

  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [WORD_BITS-1:0]  addr_word;
  logic [1:0]            addr_lane;
  logic                  lookup_hit;
  logic [31:0]           cur_word;
  logic [7:0]            sel_byte;
  logic [3:0]            wr_be;
  logic [31:0]           wr_word;

  assign addr_tag   = addr[31 -: TAG_BITS];
  assign addr_index = addr[OFFSET_BITS +: INDEX_BITS];
  assign addr_word  = addr[2 +: WORD_BITS];
  assign addr_lane  = addr[1:0];

  assign lookup_hit = valid[addr_index] && (tag_mem[addr_index] == addr_tag);
  assign cur_word   = data_mem[{addr_index, addr_word}];
  assign sel_byte   = cur_word[{addr_lane, 3'b000} +: 8];
  assign rdata      = is_byte ? {{24{sel_byte[7]}}, sel_byte} : cur_word;

  // Byte stores replicate the byte on every lane so the memory only needs be.
  assign wr_be   = is_byte ? (4'b0001 << addr_lane) : 4'b1111;
  assign wr_word = is_byte ? {4{wdata[7:0]}} : wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      refill_cnt <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (!wr_en && rd_en && !lookup_hit) begin
            miss_count         <= miss_count + 32'd1;
            valid[addr_index]  <= 1'b0;
            refill_cnt         <= '0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            refill_cnt <= refill_cnt + 1'b1;
            if (refill_cnt == LAST_WORD) valid[addr_index] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; a reset edge suppresses any update so
  // an aborted refill or store leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!reset && mem_ack) begin
      if (state == REFILL) begin
        data_mem[{addr_index, refill_cnt}] <= mem_rdata;
        if (refill_cnt == LAST_WORD) tag_mem[addr_index] <= addr_tag;
      end else if (state == WRITE_MEM && lookup_hit) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wr_be[b]) data_mem[{addr_index, addr_word}][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    hit        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          state_next = WRITE_MEM;
        end else if (rd_en) begin
          if (lookup_hit) hit = 1'b1;
          else            state_next = REFILL;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_tag, addr_index, refill_cnt, 2'b00};
        if (mem_ack && refill_cnt == LAST_WORD) state_next = IDLE;
      end
      WRITE_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = wr_word;
        mem_be    = wr_be;
        if (mem_ack) state_next = WDONE;
      end
      WDONE: begin
        hit        = rd_en | wr_en;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Testbench for data_cache_controller: table of load/store records with
// hand-computed results, plus a reset-during-refill sequence. A small memory
// responder acknowledges each request two cycles after it appears.
module tb_data_cache_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic        is_byte = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] miss_count;

  data_cache_controller #(.INDEX_BITS(5), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .is_byte(is_byte),
    .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Memory model and responder
  logic [31:0] mem_model [4096];
  logic [31:0] rd_log [$];
  int          rd_req_cnt = 0;
  int          wr_req_cnt = 0;
  int          wait_cnt = 0;
  int          last_ack_cyc = 0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;

  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
    end else if (mem_req) begin
      if (wait_cnt == 1) begin
        wait_cnt     = 0;
        mem_ack      = 1'b1;
        last_ack_cyc = cyc;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_model[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          last_be    = mem_be;
          last_wdata = mem_wdata;
          last_waddr = mem_addr;
          wr_req_cnt++;
        end else begin
          mem_rdata = mem_model[mem_addr[13:2]];
          rd_log.push_back(mem_addr);
          rd_req_cnt++;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  typedef struct {
    logic        rd, wr, byt;
    logic [31:0] addr, wdata;
    logic [31:0] exp_rdata, exp_miss;
    int          exp_rreq, exp_wreq;
    logic [31:0] exp_base;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_waddr;
  } vec_t;

  function automatic vec_t ld(logic byt, logic [31:0] a, logic [31:0] exp, logic [31:0] miss,
                              int rreq, logic [31:0] base);
    vec_t v;
    v.rd = 1'b1; v.wr = 1'b0; v.byt = byt; v.addr = a; v.wdata = 32'h5A5A_5A5A;
    v.exp_rdata = exp; v.exp_miss = miss; v.exp_rreq = rreq; v.exp_wreq = 0;
    v.exp_base = base; v.exp_be = '0; v.exp_wdata = '0; v.exp_waddr = '0;
    return v;
  endfunction

  function automatic vec_t st(logic rd, logic byt, logic [31:0] a, logic [31:0] wd, logic [31:0] miss,
                              logic [3:0] be, logic [31:0] ewd, logic [31:0] waddr);
    vec_t v;
    v.rd = rd; v.wr = 1'b1; v.byt = byt; v.addr = a; v.wdata = wd;
    v.exp_rdata = '0; v.exp_miss = miss; v.exp_rreq = 0; v.exp_wreq = 1;
    v.exp_base = '0; v.exp_be = be; v.exp_wdata = ewd; v.exp_waddr = waddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 with requests deasserted.
  task automatic check_access(input vec_t v, input string tag);
    int rd0, wr0, start_cyc, exp_cyc;
    bit got;
    rd0 = rd_req_cnt; wr0 = wr_req_cnt; start_cyc = cyc;
    rd_log.delete();
    rd_en = v.rd; wr_en = v.wr; is_byte = v.byt; addr = v.addr; wdata = v.wdata;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (hit === 1'b1) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: hit not seen within 200 cycles", tag);
    end else begin
      if (v.rd && !v.wr) chk({tag, " rdata"}, rdata, v.exp_rdata);
      chk({tag, " miss_count"}, miss_count, v.exp_miss);
      chk({tag, " read reqs"}, 32'(rd_req_cnt - rd0), 32'(v.exp_rreq));
      chk({tag, " write reqs"}, 32'(wr_req_cnt - wr0), 32'(v.exp_wreq));
      chk({tag, " mem_req at hit"}, 32'(mem_req), 32'd0);
      exp_cyc = (v.exp_rreq + v.exp_wreq > 0) ? last_ack_cyc + 1 : start_cyc;
      chk({tag, " hit cycle"}, 32'(cyc), 32'(exp_cyc));
      if (v.exp_wreq > 0) begin
        chk({tag, " mem_be"}, 32'(last_be), 32'(v.exp_be));
        chk({tag, " mem_wdata"}, last_wdata, v.exp_wdata);
        chk({tag, " mem_addr wr"}, last_waddr, v.exp_waddr);
      end
      if (v.exp_rreq > 0 && rd_log.size() == v.exp_rreq) begin
        for (int i = 0; i < v.exp_rreq; i++)
          chk($sformatf("%s refill addr %0d", tag, i), rd_log[i], v.exp_base + 32'(4*i));
      end
    end
    @(posedge clk); #2;
    rd_en = 1'b0; wr_en = 1'b0; is_byte = 1'b0;
  endtask

  vec_t vecs [20];

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = '0;
    mem_model['h40 >> 2]  = 32'h11; mem_model['h44 >> 2]  = 32'h22;
    mem_model['h48 >> 2]  = 32'h33; mem_model['h4C >> 2]  = 32'h44;
    mem_model['h840 >> 2] = 32'h55; mem_model['h844 >> 2] = 32'h66;
    mem_model['h848 >> 2] = 32'h77; mem_model['h84C >> 2] = 32'h88;
    mem_model['h200 >> 2] = 32'hCAFE_0001; mem_model['h204 >> 2] = 32'hCAFE_0002;
    mem_model['h208 >> 2] = 32'hCAFE_0003; mem_model['h20C >> 2] = 32'hCAFE_0004;

    vecs[0]  = ld(0, 32'h40,   32'h11,        1, 4, 32'h40);
    vecs[1]  = ld(0, 32'h4C,   32'h44,        1, 0, 0);
    vecs[2]  = ld(0, 32'h44,   32'h22,        1, 0, 0);
    vecs[3]  = st(0, 0, 32'h40,   32'h0000_80FF, 1, 4'b1111, 32'h0000_80FF, 32'h40);
    vecs[4]  = ld(1, 32'h41,   32'hFFFF_FF80, 1, 0, 0);
    vecs[5]  = ld(1, 32'h40,   32'hFFFF_FFFF, 1, 0, 0);
    vecs[6]  = st(0, 1, 32'h42,   32'h1234_56AB, 1, 4'b0100, 32'hABAB_ABAB, 32'h40);
    vecs[7]  = ld(0, 32'h40,   32'h00AB_80FF, 1, 0, 0);
    vecs[8]  = ld(1, 32'h42,   32'hFFFF_FFAB, 1, 0, 0);
    vecs[9]  = ld(0, 32'h840,  32'h55,        2, 4, 32'h840);
    vecs[10] = ld(0, 32'h84C,  32'h88,        2, 0, 0);
    vecs[11] = ld(0, 32'h40,   32'h00AB_80FF, 3, 4, 32'h40);
    vecs[12] = st(0, 0, 32'h1000, 32'hDEAD_BEEF, 3, 4'b1111, 32'hDEAD_BEEF, 32'h1000);
    vecs[13] = ld(0, 32'h1000, 32'hDEAD_BEEF, 4, 4, 32'h1000);
    vecs[14] = st(0, 1, 32'h1003, 32'h0000_0012, 4, 4'b1000, 32'h1212_1212, 32'h1000);
    vecs[15] = ld(0, 32'h1000, 32'h12AD_BEEF, 4, 0, 0);
    vecs[16] = ld(1, 32'h1001, 32'hFFFF_FFBE, 4, 0, 0);
    vecs[17] = ld(1, 32'h1003, 32'h0000_0012, 4, 0, 0);
    vecs[18] = st(1, 0, 32'h1004, 32'h0102_0304, 4, 4'b1111, 32'h0102_0304, 32'h1004);
    vecs[19] = ld(0, 32'h1007, 32'h0102_0304, 4, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset hit", 32'(hit), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset miss_count", miss_count, 32'd0);
    reset = 1'b0;
    @(posedge clk); #2;

    for (int i = 0; i < 20; i++) check_access(vecs[i], $sformatf("vec%0d", i));

    // Reset after two refill acks of a miss to line 0
    begin
      int base;
      bit reached;
      base = rd_req_cnt; reached = 1'b0;
      rd_en = 1'b1; wr_en = 1'b0; is_byte = 1'b0; addr = 32'h200;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #2;
        if (rd_req_cnt - base >= 2) begin reached = 1'b1; break; end
      end
      if (!reached) begin
        n_checks++; n_fail++;
        $display("FAIL midreset timeout: two refill acks not seen");
      end
      reset = 1'b1;
      @(posedge clk); #2;
      chk("midreset mem_req", 32'(mem_req), 32'd0);
      chk("midreset miss_count", miss_count, 32'd0);
      chk("midreset hit", 32'(hit), 32'd0);
      reset = 1'b0;
      check_access(ld(0, 32'h200, 32'hCAFE_0001, 1, 4, 32'h200), "after reset 0x200");
      check_access(ld(0, 32'h20C, 32'hCAFE_0004, 1, 0, 0), "after reset 0x20C");
      check_access(ld(0, 32'h40, 32'h00AB_80FF, 2, 4, 32'h40), "after reset 0x40");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache_controller.md
Name: data_cache_controller

Overview:
Direct-mapped, write-through, no-write-allocate data cache that sits between the datapath's load/store path and main memory. It consumes the control unit's memory-access signals (load, store, byte select) and produces `hit`, the completion strobe the control unit uses to gate `pc_we` for memory instructions. Misses are refilled one word at a time over a req/ack memory handshake.

Parameters:
- INDEX_BITS, 5, line index width; NUM_LINES = 2^INDEX_BITS = 32.
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2); OFFSET_BITS = log2(WORDS_PER_LINE) + 2.
- TAG_BITS, 32-INDEX_BITS-OFFSET_BITS, derived; not overridable.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- rd_en, input, 1, load request (LW/LB); held stable until hit.
- wr_en, input, 1, store request (SW/SB); held stable until hit.
- is_byte, input, 1, byte access (LB/SB) when 1, word access when 0.
- addr, input, 32, byte address: {tag, index, word, byte}.
- wdata, input, 32, store data; SB uses wdata[7:0].
- rdata, output, 32, load data; LB sign-extends the selected byte.
- hit, output, 1, access complete this cycle.
- mem_req, output, 1, memory request.
- mem_we, output, 1, memory write when 1, read when 0.
- mem_addr, output, 32, word-aligned memory address.
- mem_wdata, output, 32, memory write data.
- mem_be, output, 4, memory byte enables.
- mem_rdata, input, 32, memory read data; valid when mem_ack=1.
- mem_ack, input, 1, one-cycle completion of the current mem_req.
- miss_count, output, 32, read-miss counter; wraps modulo 2^32.

Behaviour:
- Reset: all valid bits=0, state=IDLE, mem_req=0, mem_we=0, mem_be=0, miss_count=0, hit=0. Data and tag arrays are not cleared.
- Reset mid-refill or mid-write aborts immediately. The line being refilled stays invalid. mem_req drops the next cycle.
- Byte lanes are little-endian: lane = addr[1:0]. Word accesses ignore addr[1:0].
- If rd_en and wr_en are both 1, wr_en wins.
- IDLE, read:
  - If valid[index] and tag match, hit=1 combinationally in the same cycle, with rdata = selected word, or sign-extended byte for is_byte.
  - Otherwise (miss): hit=0, miss_count++, valid[index] cleared, refill word counter=0, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={tag,index,cnt,2'b00}.
  - On mem_ack, write mem_rdata to line word cnt and increment cnt.
  - On the ack for word WORDS_PER_LINE-1, write tag, set valid=1, return to IDLE.
  - The retried lookup then hits, so read-miss latency = 4 acks + 1 cycle.
- IDLE, write: go to WRITE_MEM; hit=0 in this cycle.
- WRITE_MEM:
  - mem_req=1, mem_we=1, mem_addr={addr[31:2],2'b00}.
  - mem_be: 4'b1111 for a word access; one-hot of addr[1:0] for a byte access.
  - mem_wdata: wdata for a word access; wdata[7:0] replicated on all lanes for a byte access.
  - On mem_ack: if the line is valid and the tag matches, merge the enabled bytes into the cached word in the same edge. Go to WDONE. A write miss leaves the cache unchanged.
- WDONE: hit=1 for exactly one cycle, then IDLE. The next cycle belongs to the next instruction.
- hit is 0 in REFILL and WRITE_MEM, and whenever rd_en=wr_en=0.
- mem_req stays asserted with stable mem_addr, mem_we, mem_wdata and mem_be until mem_ack. Each ack retires exactly one request. mem_ack while mem_req=0 is ignored.
- rdata is don't-care when hit=0.

Test Plan:
- Cold read: reset, then rd_en with addr=0x0000_0040 and memory returning 0x11,0x22,0x33,0x44 with 2-cycle ack latency -> 4 read reqs at 0x40, 0x44, 0x48, 0x4C; then hit=1 with rdata=0x11; miss_count=1.
- Warm read: next rd_en at addr=0x4C -> hit=1 in the same cycle, rdata=0x44, no mem_req, miss_count still 1.
- LB sign extension: line word at 0x40 holds 0x0000_80FF; LB at addr=0x41 -> rdata=0xFFFF_FF80; LB at 0x40 -> rdata=0xFFFF_FFFF.
- SB hit: SB at 0x42 with wdata=0xAB -> mem_we=1, mem_be=4'b0100, mem_wdata=0xABABABAB; hit one cycle after ack; then LW at 0x40 -> rdata=0x00AB_80FF.
- Conflict: read at 0x840 (same index, different tag) -> refill; a following read at 0x40 misses again; miss_count increments both times.
- Write miss and reset mid-refill: SW at 0x1000 -> memory write only, a following read at 0x1000 misses. Reset asserted after 2 refill acks -> mem_req=0 next cycle; re-reading the same address issues all 4 refills again.
